// File: rtl/serial_mod_residue.sv
// Serial residue engine: folds one stream bit per clock into value mod MODULUS,
// then hands the frame's residue and saturated length out on a valid/ready port.
module serial_mod_residue #(
  parameter int unsigned MODULUS   = 7,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned LEN_W     = 8,
  localparam int unsigned W        = (MODULUS > 2) ? $clog2(MODULUS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_last,
  input  logic             in_clear,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_residue,
  output logic             out_zero,
  output logic [LEN_W-1:0] out_len
);

  localparam logic [W:0]       MOD_C   = (W+1)'(MODULUS);
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  logic [W-1:0]     acc_q, acc_d, acc_nx;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     res_q, res_d;
  logic             zero_q, zero_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             accept;
  logic             frame_end;

  assign in_ready  = !rst && !in_clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && in_last;

  generate
    if (MSB_FIRST) begin : g_msb
      logic [W:0] dbl;

      always_comb begin
        dbl    = {acc_q, in_data};
        acc_nx = (dbl >= MOD_C) ? W'(dbl - MOD_C) : dbl[W-1:0];
      end
    end else begin : g_lsb
      // wgt_q tracks 2^k mod MODULUS for the bit position about to arrive.
      logic [W-1:0] wgt_q, wgt_d, wgt_nx;
      logic [W:0]   sum, wdbl;

      always_comb begin
        sum    = {1'b0, acc_q} + (in_data ? {1'b0, wgt_q} : {(W+1){1'b0}});
        acc_nx = (sum >= MOD_C) ? W'(sum - MOD_C) : sum[W-1:0];
        wdbl   = {wgt_q, 1'b0};
        wgt_nx = (wdbl >= MOD_C) ? W'(wdbl - MOD_C) : wdbl[W-1:0];
        wgt_d  = wgt_q;
        if (in_clear || frame_end) begin
          wgt_d = W'(1);
        end else if (accept) begin
          wgt_d = wgt_nx;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wgt_q <= W'(1);
        end else begin
          wgt_q <= wgt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_clear || frame_end) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_nx;
      cnt_d = cnt_nx;
    end

    // A new result may load in the same cycle the previous one is taken.
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    len_d       = len_q;
    if (frame_end) begin
      out_valid_d = 1'b1;
      res_d       = acc_nx;
      zero_d      = (acc_nx == '0);
      len_d       = cnt_nx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      len_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      len_q       <= len_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_residue = res_q;
  assign out_zero    = zero_q;
  assign out_len     = len_q;

endmodule
